boruss_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 256 x 8 BorussCPU data RAM. It sits between the instruction-fetch requester (port 0) and the load/store requester (port 1) and the single RAM port. It grants one request at a time and drives the RAM's address, data, write-enable and read-enable lines, never asserting both enables together. It returns read data with a one-cycle valid pulse on the port that issued the read.

---
 rtl/boruss_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_boruss_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/boruss_mem_arbiter.sv
// Two-port arbiter/sequencer for the 256 x 8 BorussCPU data RAM.
// Define BORUSS_MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 1 wins).
module boruss_mem_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic       req0_we,
   input  logic [7:0] req0_addr,
   input  logic [7:0] req0_wdata,
   output logic       req0_ready,
   output logic       resp0_valid,
   input  logic       req1_valid,
   input  logic       req1_we,
   input  logic [7:0] req1_addr,
   input  logic [7:0] req1_wdata,
   output logic       req1_ready,
   output logic       resp1_valid,
   output logic [7:0] resp_rdata,
   output logic       busy,
   output logic [7:0] ram_address,
   output logic [7:0] ram_data_in,
   output logic       ram_write_enable,
   output logic       ram_read_enable,
   input  logic [7:0] ram_data_out
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic       r_port;
   logic [7:0] r_ram_address;
   logic [7:0] r_ram_data_in;
   logic       r_ram_write_enable;
   logic       r_ram_read_enable;

   logic       w_grant0;
   logic       w_grant1;
   logic       w_idle;
   logic       w_accept;
   logic       w_sel_we;
   logic [7:0] w_sel_addr;
   logic [7:0] w_sel_wdata;

`ifdef BORUSS_MEM_ARB_RR_EN
   // Pointer names the port with priority; it flips to the other port on every grant.
   logic r_rr_ptr;

   assign w_grant1 = req1_valid && (!req0_valid || r_rr_ptr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr <= 1'b0;
      end else if (w_accept) begin
         r_rr_ptr <= !w_grant1;
      end
   end
`else
   assign w_grant1 = req1_valid;
`endif

   assign w_grant0 = req0_valid && !w_grant1;

   // Ready is combinational and must be suppressed while reset is held.
   assign w_idle     = (r_state == StIdle) && !reset;
   assign req0_ready = w_idle && w_grant0;
   assign req1_ready = w_idle && w_grant1;
   assign w_accept   = req0_ready || req1_ready;

   assign w_sel_we    = w_grant1 ? req1_we    : req0_we;
   assign w_sel_addr  = w_grant1 ? req1_addr  : req0_addr;
   assign w_sel_wdata = w_grant1 ? req1_wdata : req0_wdata;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StIssue;
         StIssue: w_state_next = r_ram_write_enable ? StIdle : StResp;
         StResp:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Enables are high only in the cycle after a grant, so they can never overlap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ram_address      <= 8'h00;
         r_ram_data_in      <= 8'h00;
         r_ram_write_enable <= 1'b0;
         r_ram_read_enable  <= 1'b0;
         r_port             <= 1'b0;
      end else begin
         r_ram_write_enable <= w_accept && w_sel_we;
         r_ram_read_enable  <= w_accept && !w_sel_we;
         if (w_accept) begin
            r_ram_address <= w_sel_addr;
            r_ram_data_in <= w_sel_wdata;
            r_port        <= w_grant1;
         end
      end
   end

   assign ram_address      = r_ram_address;
   assign ram_data_in      = r_ram_data_in;
   assign ram_write_enable = r_ram_write_enable;
   assign ram_read_enable  = r_ram_read_enable;

   assign busy        = (r_state != StIdle);
   assign resp0_valid = (r_state == StResp) && !r_port;
   assign resp1_valid = (r_state == StResp) && r_port;
   assign resp_rdata  = ram_data_out;

endmodule

// File: tb/tb_boruss_mem_arbiter.sv
// Directed self-checking bench for boruss_mem_arbiter with a small 256 x 8 RAM model attached.
module tb_boruss_mem_arbiter;

   logic       clk;
   logic       reset;
   logic       req0_valid, req0_we, req0_ready, resp0_valid;
   logic       req1_valid, req1_we, req1_ready, resp1_valid;
   logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
   logic [7:0] resp_rdata, ram_address, ram_data_in, ram_data_out;
   logic       busy, ram_write_enable, ram_read_enable;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mem [256];

   boruss_mem_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .req0_valid       (req0_valid),
      .req0_we          (req0_we),
      .req0_addr        (req0_addr),
      .req0_wdata       (req0_wdata),
      .req0_ready       (req0_ready),
      .resp0_valid      (resp0_valid),
      .req1_valid       (req1_valid),
      .req1_we          (req1_we),
      .req1_addr        (req1_addr),
      .req1_wdata       (req1_wdata),
      .req1_ready       (req1_ready),
      .resp1_valid      (resp1_valid),
      .resp_rdata       (resp_rdata),
      .busy             (busy),
      .ram_address      (ram_address),
      .ram_data_in      (ram_data_in),
      .ram_write_enable (ram_write_enable),
      .ram_read_enable  (ram_read_enable),
      .ram_data_out     (ram_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: registered read, cleared by the shared reset.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
         ram_data_out <= 8'h00;
      end else begin
         if (ram_write_enable) mem[ram_address] <= ram_data_in;
         if (ram_read_enable) ram_data_out <= mem[ram_address];
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!reset) chk("en_excl", {7'b0, ram_write_enable & ram_read_enable}, 8'h00);
   end

   int exp_port;

   initial begin
      reset = 1'b1;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
      #2;
      chk("rst_ready0", {7'b0, req0_ready}, 8'h00);
      chk("rst_ready1", {7'b0, req1_ready}, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'h00);
      chk("rst_resp", {6'b0, resp1_valid, resp0_valid}, 8'h00);
      chk("rst_addr", ram_address, 8'h00);
      chk("rst_din", ram_data_in, 8'h00);
      chk("rst_en", {6'b0, ram_write_enable, ram_read_enable}, 8'h00);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Port 0 write 0x10 <- 0xA5
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h10; req0_wdata = 8'hA5;
      #1;
      chk("w0_ready0", {7'b0, req0_ready}, 8'h01);
      chk("w0_ready1", {7'b0, req1_ready}, 8'h00);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("w0_we", {7'b0, ram_write_enable}, 8'h01);
      chk("w0_re", {7'b0, ram_read_enable}, 8'h00);
      chk("w0_addr", ram_address, 8'h10);
      chk("w0_din", ram_data_in, 8'hA5);
      chk("w0_busy", {7'b0, busy}, 8'h01);
      tick();
      chk("w0_we_off", {7'b0, ram_write_enable}, 8'h00);
      chk("w0_idle", {7'b0, busy}, 8'h00);
      chk("w0_noresp", {6'b0, resp1_valid, resp0_valid}, 8'h00);

      // Port 1 read 0x10 -> 0xA5, response two cycles after acceptance
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h10;
      #1;
      chk("r1_ready1", {7'b0, req1_ready}, 8'h01);
      tick();
      req1_valid = 1'b0;
      #1;
      chk("r1_re", {7'b0, ram_read_enable}, 8'h01);
      chk("r1_we", {7'b0, ram_write_enable}, 8'h00);
      chk("r1_addr", ram_address, 8'h10);
      chk("r1_early", {7'b0, resp1_valid}, 8'h00);
      tick();
      chk("r1_resp1", {7'b0, resp1_valid}, 8'h01);
      chk("r1_resp0", {7'b0, resp0_valid}, 8'h00);
      chk("r1_rdata", resp_rdata, 8'hA5);
      chk("r1_re_off", {7'b0, ram_read_enable}, 8'h00);
      tick();
      chk("r1_resp_end", {7'b0, resp1_valid}, 8'h00);
      chk("r1_idle", {7'b0, busy}, 8'h00);

      // Both ports reading continuously: six grants
      reset = 1'b1;
      #1;
      reset = 1'b0;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h40;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h41;
      for (int i = 0; i < 6; i++) begin
         #1;
`ifdef BORUSS_MEM_ARB_RR_EN
         exp_port = i % 2;
`else
         exp_port = 1;
`endif
         chk("arb_ready0", {7'b0, req0_ready}, (exp_port == 0) ? 8'h01 : 8'h00);
         chk("arb_ready1", {7'b0, req1_ready}, (exp_port == 1) ? 8'h01 : 8'h00);
         tick();
         chk("arb_addr", ram_address, (exp_port == 1) ? 8'h41 : 8'h40);
         chk("arb_busy_ready", {6'b0, req1_ready, req0_ready}, 8'h00);
         tick();
         chk("arb_resp", {6'b0, resp1_valid, resp0_valid}, (exp_port == 1) ? 8'h02 : 8'h01);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Back-to-back writes to 0x00 and 0xFF with valid held through busy
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h00; req0_wdata = 8'h3C;
      #1;
      chk("bb_ready_a", {7'b0, req0_ready}, 8'h01);
      tick();
      req0_addr = 8'hFF; req0_wdata = 8'hC3;
      #1;
      chk("bb_busy_ready", {7'b0, req0_ready}, 8'h00);
      chk("bb_addr_a", ram_address, 8'h00);
      chk("bb_din_a", ram_data_in, 8'h3C);
      chk("bb_we_a", {7'b0, ram_write_enable}, 8'h01);
      tick();
      chk("bb_ready_b", {7'b0, req0_ready}, 8'h01);
      chk("bb_we_gap", {7'b0, ram_write_enable}, 8'h00);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("bb_addr_b", ram_address, 8'hFF);
      chk("bb_din_b", ram_data_in, 8'hC3);
      chk("bb_we_b", {7'b0, ram_write_enable}, 8'h01);
      tick();
      chk("bb_hold_addr", ram_address, 8'hFF);
      chk("bb_idle", {7'b0, busy}, 8'h00);

      // Read back 0xFF and 0x00 on port 1
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'hFF;
      #1;
      tick();
      req1_addr = 8'h00;
      tick();
      chk("rb_ff", resp_rdata, 8'hC3);
      chk("rb_ff_v", {7'b0, resp1_valid}, 8'h01);
      tick();
      tick();
      req1_valid = 1'b0;
      tick();
      chk("rb_00", resp_rdata, 8'h3C);
      chk("rb_00_v", {7'b0, resp1_valid}, 8'h01);
      tick();

      // Write 0x20 <- 0x77, then reset while its read is in RESP
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h20; req1_wdata = 8'h77;
      #1;
      chk("rs_wready", {7'b0, req1_ready}, 8'h01);
      tick();
      req1_valid = 1'b0;
      tick();
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h20; req0_wdata = 8'h55;
      #1;
      chk("rs_rready", {7'b0, req0_ready}, 8'h01);
      tick();
      chk("rs_re", {7'b0, ram_read_enable}, 8'h01);
      chk("rs_din", ram_data_in, 8'h55);
      @(posedge clk);
      reset = 1'b1;
      #1;
      chk("rs_noresp", {6'b0, resp1_valid, resp0_valid}, 8'h00);
      chk("rs_addr0", ram_address, 8'h00);
      chk("rs_din0", ram_data_in, 8'h00);
      chk("rs_en0", {6'b0, ram_write_enable, ram_read_enable}, 8'h00);
      chk("rs_ready_forced", {7'b0, req0_ready}, 8'h00);
      chk("rs_busy", {7'b0, busy}, 8'h00);
      tick();
      chk("rs_noresp2", {6'b0, resp1_valid, resp0_valid}, 8'h00);
      reset = 1'b0;
      #1;
      chk("rs_post_ready", {7'b0, req0_ready}, 8'h01);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("rs_post_addr", ram_address, 8'h20);
      tick();
      chk("rs_post_v", {7'b0, resp0_valid}, 8'h01);
      chk("rs_post_data", resp_rdata, 8'h00);
      tick();
      chk("rs_post_idle", {7'b0, busy}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
